collision_monitor: RTL

- Sits directly downstream of the level block generators; consumes their per-pixel `blocks[15:0]` and the player sprite's per-pixel hit flag.
- Detects player/block overlap during each scanned frame and tracks lives.
- Runs the play / invulnerable / game-over state machine.
- Drives `freeze`, which the top level uses to gate the `update` strobe to the block generators.

---
 rtl/runner_pkg.sv | 23 ++
 rtl/frame_hit_accumulator.sv | 34 +++
 rtl/collision_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/runner_pkg.sv
// Shared constants for the runner game blocks: FSM encoding, screen limits, field widths.
package runner_pkg;

  localparam int unsigned LIVES_W   = 2;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned BLOCKS_W  = 16;
  localparam int unsigned INV_W     = 8;
  localparam int unsigned FRAME_W   = 8;
  localparam int unsigned SCORE_W   = 16;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  localparam logic [1:0] ST_PLAY   = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_OVER   = 2'd2;

  // True when the pixel lies in the active (non-blanking) area.
  function automatic logic in_visible(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
    return (x < COORD_W'(H_VISIBLE)) && (y < COORD_W'(V_VISIBLE));
  endfunction

endpackage

// File: rtl/frame_hit_accumulator.sv
// Collects player/block overlap over one scanned frame; reports it on the frame_end cycle.
module frame_hit_accumulator
  import runner_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [COORD_W-1:0]  x_count,
  input  logic [COORD_W-1:0]  y_count,
  input  logic [BLOCKS_W-1:0] blocks,
  input  logic                player,
  input  logic                frame_end,
  input  logic                clear,
  output logic                frame_hit_c
);

  logic pix_hit_c;
  logic hit_acc;

  assign pix_hit_c = player & (|blocks) & in_visible(x_count, y_count);

  // A hit on the frame_end pixel still belongs to the closing frame.
  assign frame_hit_c = frame_end & (hit_acc | pix_hit_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_acc <= 1'b0;
    end else if (frame_end || clear) begin
      hit_acc <= 1'b0;
    end else begin
      hit_acc <= hit_acc | pix_hit_c;
    end
  end

endmodule

// File: rtl/collision_monitor.sv
// Player/block collision detection, lives and play/invulnerable/game-over FSM.
// Optional frame-survived score counter built only when COLLISION_SCORE_EN is defined.
module collision_monitor
  import runner_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned FLASH_SHIFT   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COORD_W-1:0]  xCount,
  input  logic [COORD_W-1:0]  yCount,
  input  logic [BLOCKS_W-1:0] blocks,
  input  logic                player,
  input  logic                frame_end,
  input  logic                restart,
  output logic                collision,
  output logic [LIVES_W-1:0]  lives,
  output logic                game_over,
  output logic                freeze,
  output logic                hit_flash,
  output logic [SCORE_W-1:0]  score
);

  logic               frame_hit_c;
  logic               acc_clear_c;
  logic [1:0]         state, state_d;
  logic [LIVES_W-1:0] lives_d;
  logic [INV_W-1:0]   inv_cnt, inv_cnt_d;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_d;
  logic               collision_d;
  logic               game_over_d;
  logic               hit_flash_d;

  frame_hit_accumulator u_acc (
    .clk         (clk),
    .rst         (rst),
    .x_count     (xCount),
    .y_count     (yCount),
    .blocks      (blocks),
    .player      (player),
    .frame_end   (frame_end),
    .clear       (acc_clear_c),
    .frame_hit_c (frame_hit_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    lives_d     = lives;
    inv_cnt_d   = inv_cnt;
    collision_d = 1'b0;
    acc_clear_c = 1'b0;
    frame_cnt_d = frame_end ? FRAME_W'(frame_cnt + FRAME_W'(1)) : frame_cnt;

    case (state)
      ST_PLAY: begin
        if (frame_hit_c) begin
          collision_d = 1'b1;
          if (lives > LIVES_W'(1)) begin
            lives_d   = LIVES_W'(lives - LIVES_W'(1));
            inv_cnt_d = INV_W'(INVULN_FRAMES);
            state_d   = ST_INVULN;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
          end
        end
      end
      ST_INVULN: begin
        if (frame_end) begin
          if (inv_cnt <= INV_W'(1)) begin
            inv_cnt_d = '0;
            state_d   = ST_PLAY;
          end else begin
            inv_cnt_d = INV_W'(inv_cnt - INV_W'(1));
          end
        end
      end
      ST_OVER: begin
        if (restart) begin
          state_d     = ST_PLAY;
          lives_d     = LIVES_W'(LIVES);
          acc_clear_c = 1'b1;
        end
      end
      default: state_d = ST_PLAY;
    endcase

    game_over_d = (state_d == ST_OVER);
    hit_flash_d = (state_d == ST_INVULN) & frame_cnt_d[FLASH_SHIFT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PLAY;
      lives     <= LIVES_W'(LIVES);
      inv_cnt   <= '0;
      frame_cnt <= '0;
      collision <= 1'b0;
      game_over <= 1'b0;
      freeze    <= 1'b0;
      hit_flash <= 1'b0;
    end else begin
      state     <= state_d;
      lives     <= lives_d;
      inv_cnt   <= inv_cnt_d;
      frame_cnt <= frame_cnt_d;
      collision <= collision_d;
      game_over <= game_over_d;
      freeze    <= game_over_d;
      hit_flash <= hit_flash_d;
    end
  end

`ifdef COLLISION_SCORE_EN
  logic [SCORE_W-1:0] score_d;

  // Frames survived: counts in PLAY/INVULN, holds in OVER, saturates.
  always_comb begin
    score_d = score;
    if (state == ST_OVER) begin
      if (restart) score_d = '0;
    end else if (frame_end && (score != {SCORE_W{1'b1}})) begin
      score_d = SCORE_W'(score + SCORE_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score <= '0;
    end else begin
      score <= score_d;
    end
  end
`else
  assign score = '0;
`endif

endmodule
